// File: rtl/gpi_pkg.sv
// Shared definitions for the general-purpose input block: register offsets
// and the debounce counter type.
package gpi_pkg;

  localparam logic [1:0] GPI_DATA   = 2'd0;
  localparam logic [1:0] GPI_STATUS = 2'd1;
  localparam logic [1:0] GPI_MASK   = 2'd2;
  localparam logic [1:0] GPI_RAW    = 2'd3;

  localparam int DB_CNT_W = 16;

  typedef logic [DB_CNT_W-1:0] db_cnt_t;

endpackage

// File: rtl/gpi_if.sv
// Register-slot bus between a host and the GPI core.
interface gpi_if;

  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (
    output cs, read, write, addr, write_data,
    input  read_data
  );

  modport slave (
    input  cs, read, write, addr, write_data,
    output read_data
  );

endinterface

// File: rtl/gpi_debounce.sv
// One-bit debouncer: db follows sync only after DB_CYCLES consecutive mismatching clocks.
// Build option GPI_CORE_DEBOUNCE_EN; when undefined db is the synchronized bit itself.
module gpi_debounce
  import gpi_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_next,
  input  logic sync,
  output logic db,
  output logic change
);

`ifdef GPI_CORE_DEBOUNCE_EN

  localparam db_cnt_t CNT_LAST = db_cnt_t'(DB_CYCLES - 1);

  db_cnt_t cnt_reg;
  db_cnt_t cnt_next;
  logic    db_reg;
  logic    db_next;
  logic    unused_ok;

  assign unused_ok = sync_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      db_reg  <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      db_reg  <= db_next;
    end
  end

  // Any agreeing clock restarts the run; the count stops at CNT_LAST so it never wraps.
  always_comb begin
    cnt_next = '0;
    db_next  = db_reg;
    change   = 1'b0;
    if (sync != db_reg) begin
      if (cnt_reg == CNT_LAST) begin
        db_next = sync;
        change  = 1'b1;
      end else begin
        cnt_next = cnt_reg + db_cnt_t'(1);
      end
    end
  end

  assign db = db_reg;

`else

  logic unused_ok;

  assign unused_ok = ^{clk, rst, 1'(DB_CYCLES)};

  // db is the second synchronizer flop; it changes on the edge where the first flop differs.
  assign db     = sync;
  assign change = sync ^ sync_next;

`endif

endmodule

// File: rtl/gpi_core.sv
// Debounced general-purpose input block with sticky change status, mask and level irq.
// Build option GPI_CORE_DEBOUNCE_EN enables the per-bit debounce counters.
module gpi_core
  import gpi_pkg::*;
#(
  parameter int W         = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  gpi_if.slave         bus,
  input  logic [W-1:0] data_in,
  output logic         irq
);

  logic [W-1:0] sync1_reg;
  logic [W-1:0] sync2_reg;
  logic [W-1:0] db;
  logic [W-1:0] change;
  logic [W-1:0] status_reg;
  logic [W-1:0] status_next;
  logic [W-1:0] mask_reg;
  logic [W-1:0] mask_next;
  logic [W-1:0] w1c;
  logic         irq_reg;
  logic         wr_en;
  logic [31:0]  rd_mux;
  logic         unused_bus;

  assign unused_bus = ^{bus.addr[4:2], bus.write_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= data_in;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      gpi_debounce #(
        .DB_CYCLES (DB_CYCLES)
      ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sync_next (sync1_reg[gi]),
        .sync      (sync2_reg[gi]),
        .db        (db[gi]),
        .change    (change[gi])
      );
    end
  endgenerate

  assign wr_en = bus.cs & bus.write;

  // Set is OR-ed in after the clear so a simultaneous change keeps the bit.
  always_comb begin
    w1c       = '0;
    mask_next = mask_reg;
    if (wr_en && bus.addr[1:0] == GPI_STATUS) begin
      w1c = bus.write_data[W-1:0];
    end
    if (wr_en && bus.addr[1:0] == GPI_MASK) begin
      mask_next = bus.write_data[W-1:0];
    end
    status_next = (status_reg & ~w1c) | change;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_reg <= '0;
      mask_reg   <= '0;
      irq_reg    <= 1'b0;
    end else begin
      status_reg <= status_next;
      mask_reg   <= mask_next;
      irq_reg    <= |(status_reg & mask_reg);
    end
  end

  assign irq = irq_reg;

  always_comb begin
    rd_mux = '0;
    if (bus.cs && bus.read) begin
      case (bus.addr[1:0])
        GPI_DATA:   rd_mux = 32'(db);
        GPI_STATUS: rd_mux = 32'(status_reg);
        GPI_MASK:   rd_mux = 32'(mask_reg);
        GPI_RAW:    rd_mux = 32'(sync2_reg);
        default:    rd_mux = '0;
      endcase
    end
  end

  assign bus.read_data = rd_mux;

endmodule

// File: tb/tb_gpi_core.sv
// Directed bench for gpi_core: a table of input patterns plus hand-written
// sequences for latency, glitches, irq, set/clear collision and reset mid-debounce.
module tb_gpi_core;

  localparam int W   = 4;
  localparam int DBC = 16;
`ifdef GPI_CORE_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = 2 + DBC;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 2;
`endif

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_MASK   = 2'd2;
  localparam logic [1:0] A_RAW    = 2'd3;

  typedef struct {
    logic [3:0] din;
    logic [3:0] exp_data;
    logic [3:0] exp_status;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] data_in = '0;
  logic         irq;
  logic [2:0]   alias_q = 3'd0;
  int           tests = 0;
  int           fails = 0;
  vec_t         vecs[5];

  gpi_if bus ();

  gpi_core #(
    .W         (W),
    .DB_CYCLES (DBC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .data_in (data_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upper address bits rotate on every access so aliasing is exercised throughout.
  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus.cs   = 1'b1;
    bus.read = 1'b1;
    bus.addr = {alias_q, a};
    alias_q  = alias_q + 3'd1;
    #1;
    d        = bus.read_data;
    bus.cs   = 1'b0;
    bus.read = 1'b0;
    check(name, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cs         = 1'b1;
    bus.write      = 1'b1;
    bus.addr       = {alias_q, a};
    bus.write_data = d;
    alias_q        = alias_q + 3'd1;
    @(posedge clk);
    #1;
    bus.cs    = 1'b0;
    bus.write = 1'b0;
  endtask

  initial begin
    bus.cs         = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.addr       = '0;
    bus.write_data = '0;

    vecs[0] = '{din: 4'hA, exp_data: 4'hA, exp_status: 4'hF};
    vecs[1] = '{din: 4'hA, exp_data: 4'hA, exp_status: 4'h0};
    vecs[2] = '{din: 4'hF, exp_data: 4'hF, exp_status: 4'h5};
    vecs[3] = '{din: 4'h0, exp_data: 4'h0, exp_status: 4'hF};
    vecs[4] = '{din: 4'h3, exp_data: 4'h3, exp_status: 4'h3};

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk_reg("reset_data", A_DATA, 32'h0);
    chk_reg("reset_status", A_STATUS, 32'h0);
    chk_reg("reset_mask", A_MASK, 32'h0);
    chk_reg("reset_raw", A_RAW, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // No slot select: bus reads zero even when the selected register is nonzero
    wr(A_MASK, 32'hFFFF_FFFF);
    bus.cs   = 1'b0;
    bus.read = 1'b1;
    bus.addr = {3'b000, A_MASK};
    #1;
    check("read_without_cs", bus.read_data, 32'h0);
    bus.read = 1'b0;
    chk_reg("mask_zero_extended", A_MASK, 32'h0000_000F);
    wr(A_MASK, 32'h0);

    // Latency from a clean step after reset
    data_in = 4'b0101;
    repeat (LAT - 1) tick();
    chk_reg("data_before_latency", A_DATA, 32'h0);
    tick();
    chk_reg("data_at_latency", A_DATA, 32'h5);
    chk_reg("status_at_latency", A_STATUS, 32'h5);
    wr(A_STATUS, 32'hF);
    chk_reg("status_cleared", A_STATUS, 32'h0);

    // Table of settled input patterns
    for (int i = 0; i < 5; i++) begin
      data_in = vecs[i].din;
      repeat (LAT + 2) tick();
      chk_reg($sformatf("vec%0d_data", i), A_DATA, 32'(vecs[i].exp_data));
      chk_reg($sformatf("vec%0d_raw", i), A_RAW, 32'(vecs[i].exp_data));
      chk_reg($sformatf("vec%0d_status", i), A_STATUS, 32'(vecs[i].exp_status));
      wr(A_STATUS, 32'hF);
    end

    data_in = 4'h0;
    repeat (LAT + 2) tick();
    wr(A_STATUS, 32'hF);

    // Ten-clock pulse on bit 0
    data_in = 4'h1;
    repeat (3) tick();
    chk_reg("pulse_raw_high", A_RAW, 32'h1);
    repeat (7) tick();
    data_in = 4'h0;
    repeat (LAT + 2) tick();
    chk_reg("pulse_data_after", A_DATA, 32'h0);
    chk_reg("pulse_status_after", A_STATUS, DEB ? 32'h0 : 32'h1);
    wr(A_STATUS, 32'hF);

    // One-clock glitch that the synchronizer captures
    data_in = 4'h1;
    tick();
    data_in = 4'h0;
    tick();
    chk_reg("glitch_raw", A_RAW, 32'h1);
    chk_reg("glitch_data", A_DATA, DEB ? 32'h0 : 32'h1);
    repeat (LAT + 2) tick();
    chk_reg("glitch_data_settled", A_DATA, 32'h0);
    wr(A_STATUS, 32'hF);

    // irq follows masked status one clock later
    wr(A_MASK, 32'h1);
    chk_reg("mask_write", A_MASK, 32'h1);
    data_in = 4'h1;
    repeat (LAT) tick();
    chk_reg("irq_status_set", A_STATUS, 32'h1);
    check("irq_lags_status", {31'h0, irq}, 32'h0);
    tick();
    check("irq_asserted", {31'h0, irq}, 32'h1);
    wr(A_STATUS, 32'h1);
    chk_reg("irq_status_cleared", A_STATUS, 32'h0);
    tick();
    check("irq_deasserted", {31'h0, irq}, 32'h0);

    // Clear of bit 2 lands on the same edge that db[2] toggles
    data_in = 4'b0101;
    repeat (LAT - 1) tick();
    wr(A_STATUS, 32'h4);
    chk_reg("set_beats_clear", A_STATUS, 32'h4);
    chk_reg("collision_data", A_DATA, 32'h5);
    check("irq_masked_off", {31'h0, irq}, 32'h0);

    // Reset in the middle of a debounce run
    wr(A_MASK, 32'hF);
    tick();
    check("irq_all_mask", {31'h0, irq}, 32'h1);
    data_in = 4'b0111;
    repeat (2 + 12) tick();
    rst = 1'b1;
    #1;
    chk_reg("midrst_data", A_DATA, 32'h0);
    chk_reg("midrst_status", A_STATUS, 32'h0);
    chk_reg("midrst_mask", A_MASK, 32'h0);
    chk_reg("midrst_raw", A_RAW, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    tick();
    rst = 1'b0;
    repeat (LAT - 1) tick();
    chk_reg("postrst_data_before", A_DATA, 32'h0);
    tick();
    chk_reg("postrst_data", A_DATA, 32'h7);
    chk_reg("postrst_status", A_STATUS, 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
